// File: rtl/lane_seg_div_pkg.sv
`default_nettype none
// ============================================================================
// lane_seg_div_pkg: shared widths, states and saturation limits for the divider
// Revision: 1.0
// ============================================================================
package lane_seg_div_pkg;

   localparam int W  = 21;
   localparam int D  = 5;
   localparam int Q  = 16;
   localparam int CW = $clog2(W);

   localparam int QMAX = (1 << (Q - 1)) - 1;
   localparam int QMIN = -(1 << (Q - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/lane_seg_top_sdiv_step.sv
`default_nettype none
// ============================================================================
// lane_seg_top_sdiv_step: one restoring shift-subtract iteration (combinational)
// Revision: 1.0
// ============================================================================
module lane_seg_top_sdiv_step
   import lane_seg_div_pkg::*;
#(
   parameter int DIV_W = D
)(
   input  logic [DIV_W-1:0] i_rem,
   input  logic             i_bit,
   input  logic [DIV_W-1:0] i_div,
   output logic [DIV_W:0]   o_rem,
   output logic             o_qbit
);

   logic [DIV_W:0] w_shift;
   logic [DIV_W:0] w_div_ext;
   logic           w_ge;

   // Incoming remainder is always below the divisor, so DIV_W bits carry it.
   assign w_shift   = {i_rem, i_bit};
   assign w_div_ext = {1'b0, i_div};
   assign w_ge      = (w_shift >= w_div_ext);
   assign o_rem     = w_ge ? (w_shift - w_div_ext) : w_shift;
   assign o_qbit    = w_ge;

endmodule
`default_nettype wire

// File: rtl/lane_seg_top_sdiv_21s_5ns_16_seq.sv
`default_nettype none
// ============================================================================
// lane_seg_top_sdiv_21s_5ns_16_seq: multi-cycle signed/unsigned saturating divider
// Revision: 1.0
// ============================================================================
module lane_seg_top_sdiv_21s_5ns_16_seq
   import lane_seg_div_pkg::*;
#(
   parameter int din0_WIDTH = W,
   parameter int din1_WIDTH = D,
   parameter int dout_WIDTH = Q
)(
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_idle,
   output logic                  ap_ready,
   output logic                  ap_done,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH:0]   rem,
   output logic                  ovf,
   output logic                  dz
);

   localparam int c_W  = din0_WIDTH;
   localparam int c_D  = din1_WIDTH;
   localparam int c_Q  = dout_WIDTH;
   localparam int c_CW = $clog2(din0_WIDTH);

   localparam logic [c_CW-1:0] c_cnt_load = c_CW'(c_W - 1);
   localparam logic [c_CW-1:0] c_cnt_one  = c_CW'(1);
   localparam logic [c_W-1:0]  c_mag_one  = c_W'(1);
   localparam logic [c_W-1:0]  c_qmax_mag = c_W'((1 << (c_Q - 1)) - 1);
   localparam logic [c_W-1:0]  c_qmin_mag = c_W'(1 << (c_Q - 1));
   localparam logic [c_Q-1:0]  c_qmax     = {1'b0, {(c_Q - 1){1'b1}}};
   localparam logic [c_Q-1:0]  c_qmin     = {1'b1, {(c_Q - 1){1'b0}}};

   state_t            r_state;
   logic              r_sign;
   logic [c_W-1:0]    r_mag;
   logic [c_D-1:0]    r_div;
   logic [c_D:0]      r_prem;
   logic [c_W-1:0]    r_quo;
   logic [c_CW-1:0]   r_cnt;
   logic              r_idle;
   logic              r_done;
   logic [c_Q-1:0]    r_dout;
   logic [c_D:0]      r_rem;
   logic              r_ovf;
   logic              r_dz;

   logic [c_W-1:0]    w_abs;
   logic [c_D:0]      w_prem_nxt;
   logic              w_qbit;

   // Magnitude of the most negative dividend is 2^(W-1), which still fits unsigned.
   assign w_abs = din0[c_W-1] ? (~din0 + c_mag_one) : din0;

   lane_seg_top_sdiv_step #(
      .DIV_W (c_D)
   ) u_step (
      .i_rem  (r_prem[c_D-1:0]),
      .i_bit  (r_mag[c_W-1]),
      .i_div  (r_div),
      .o_rem  (w_prem_nxt),
      .o_qbit (w_qbit)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_mag   <= '0;
         r_div   <= '0;
         r_prem  <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_idle  <= 1'b1;
         r_done  <= 1'b0;
         r_dout  <= '0;
         r_rem   <= '0;
         r_ovf   <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (ap_start) begin
                  r_sign  <= din0[c_W-1];
                  r_mag   <= w_abs;
                  r_div   <= din1;
                  r_prem  <= '0;
                  r_quo   <= '0;
                  r_cnt   <= c_cnt_load;
                  r_idle  <= 1'b0;
                  r_state <= (din1 == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               r_mag  <= {r_mag[c_W-2:0], 1'b0};
               r_prem <= w_prem_nxt;
               r_quo  <= {r_quo[c_W-2:0], w_qbit};
               r_cnt  <= r_cnt - c_cnt_one;
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_state <= IDLE;
               r_idle  <= 1'b1;
               r_done  <= 1'b1;
               if (r_div == '0) begin
                  r_dz   <= 1'b1;
                  r_ovf  <= 1'b0;
                  r_rem  <= '0;
                  r_dout <= r_sign ? c_qmin : c_qmax;
               end else begin
                  r_dz  <= 1'b0;
                  r_rem <= r_sign ? -r_prem : r_prem;
                  if (!r_sign && (r_quo > c_qmax_mag)) begin
                     r_ovf  <= 1'b1;
                     r_dout <= c_qmax;
                  end else if (r_sign && (r_quo > c_qmin_mag)) begin
                     r_ovf  <= 1'b1;
                     r_dout <= c_qmin;
                  end else begin
                     r_ovf  <= 1'b0;
                     r_dout <= r_sign ? -r_quo[c_Q-1:0] : r_quo[c_Q-1:0];
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   assign ap_idle  = r_idle;
   assign ap_done  = r_done;
   assign ap_ready = r_done;
   assign dout     = r_dout;
   assign rem      = r_rem;
   assign ovf      = r_ovf;
   assign dz       = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_lane_seg_top_sdiv_21s_5ns_16_seq.sv
`default_nettype none
// ============================================================================
// tb_lane_seg_top_sdiv_21s_5ns_16_seq: directed scoreboard bench for the divider
// Revision: 1.0
// ============================================================================
module tb_lane_seg_top_sdiv_21s_5ns_16_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_idle, ap_ready, ap_done;
   logic [20:0] din0 = '0;
   logic [4:0]  din1 = '0;
   logic [15:0] dout;
   logic [5:0]  rem;
   logic        ovf, dz;

   typedef struct {
      logic [15:0] dout;
      logic [5:0]  rem;
      logic        ovf;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   acc    = 0;

   lane_seg_top_sdiv_21s_5ns_16_seq dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ap_start (ap_start),
      .ap_idle  (ap_idle),
      .ap_ready (ap_ready),
      .ap_done  (ap_done),
      .din0     (din0),
      .din1     (din1),
      .dout     (dout),
      .rem      (rem),
      .ovf      (ovf),
      .dz       (dz)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic exp_t mk(int q, int r, bit o, bit z, int l);
      exp_t e;
      e.dout = 16'(q);
      e.rem  = 6'(r);
      e.ovf  = o;
      e.dz   = z;
      e.lat  = l;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per ap_done and measures accept-to-done latency.
   initial begin
      exp_t e;
      forever begin
         @(negedge ap_clk);
         cyc++;
         if (ap_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("dout",    32'(dout), 32'(e.dout));
               chk("rem",     32'(rem),  32'(e.rem));
               chk("ovf",     32'(ovf),  32'(e.ovf));
               chk("dz",      32'(dz),   32'(e.dz));
               chk("ready",   32'(ap_ready), 32'd1);
               chk("latency", 32'(cyc - acc), 32'(e.lat));
            end
         end
         if (ap_idle && ap_start && !ap_rst) acc = cyc + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic wait_done();
      for (int i = 0; i < 60; i++) begin
         @(negedge ap_clk);
         if (ap_done) return;
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic launch(input logic [20:0] a, input logic [4:0] b, input exp_t e, input bit push);
      int n;
      n = 0;
      @(negedge ap_clk);
      while (!ap_idle && n < 60) begin
         @(negedge ap_clk);
         n++;
      end
      if (!ap_idle) chk("idle_timeout", 32'd0, 32'd1);
      @(posedge ap_clk); #1;
      ap_start = 1'b1;
      din0 = a;
      din1 = b;
      if (push) sb.push_back(e);
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      din0 = 21'h0ABCDE;
      din1 = 5'd7;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge ap_clk);
      chk("rst_idle", 32'(ap_idle), 32'd1);
      chk("rst_done", 32'(ap_done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_flags", {29'd0, ovf, dz, ap_ready}, 32'd0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;

      launch(21'sd20000, 5'd5, mk(4000, 0, 0, 0, 22), 1'b1);
      wait_done();

      // Output hold while the next division is in flight
      launch(-21'sd23, 5'd4, mk(-5, -3, 0, 0, 22), 1'b1);
      repeat (5) @(negedge ap_clk);
      chk("hold_dout", 32'(dout), 32'd4000);
      wait_done();

      launch(21'sd23,       5'd4,  mk(5, 3, 0, 0, 22),            1'b1); wait_done();
      launch(-21'sd1048576, 5'd31, mk(-32768, -1, 1, 0, 22),      1'b1); wait_done();
      launch(21'sd1048575,  5'd1,  mk(32767, 0, 1, 0, 22),        1'b1); wait_done();
      launch(21'sd100,      5'd0,  mk(32767, 0, 0, 1, 1),         1'b1); wait_done();
      launch(-21'sd5,       5'd0,  mk(-32768, 0, 0, 1, 1),        1'b1); wait_done();
      launch(21'sd32767,    5'd1,  mk(32767, 0, 0, 0, 22),        1'b1); wait_done();
      launch(-21'sd32768,   5'd1,  mk(-32768, 0, 0, 0, 22),       1'b1); wait_done();

      // Start pulse mid-CALC must be ignored
      launch(21'sd23, 5'd4, mk(5, 3, 0, 0, 22), 1'b1);
      repeat (5) @(posedge ap_clk); #1;
      ap_start = 1'b1;
      din0 = 21'sd100;
      din1 = 5'd0;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      wait_done();
      repeat (5) @(negedge ap_clk);

      // Back-to-back with ap_start held high
      @(posedge ap_clk); #1;
      ap_start = 1'b1;
      din0 = 21'sd20000;   din1 = 5'd5;
      sb.push_back(mk(4000, 0, 0, 0, 22));
      wait_done();
      din0 = -21'sd100000; din1 = 5'd7;
      sb.push_back(mk(-14285, -5, 0, 0, 22));
      wait_done();
      din0 = 21'sd32768;   din1 = 5'd1;
      sb.push_back(mk(32767, 0, 1, 0, 22));
      wait_done();
      din0 = -21'sd32768;  din1 = 5'd1;
      sb.push_back(mk(-32768, 0, 0, 0, 22));
      wait_done();
      ap_start = 1'b0;
      repeat (3) @(negedge ap_clk);

      // Reset mid-operation: no done, outputs cleared, then a clean run
      launch(21'sd20000, 5'd5, mk(0, 0, 0, 0, 0), 1'b0);
      repeat (9) @(posedge ap_clk); #1;
      ap_rst = 1'b1;
      @(negedge ap_clk);
      chk("midrst_idle", 32'(ap_idle), 32'd1);
      chk("midrst_done", 32'(ap_done), 32'd0);
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_rem",  32'(rem), 32'd0);
      chk("midrst_flags", {30'd0, ovf, dz}, 32'd0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      repeat (30) @(negedge ap_clk);
      launch(21'sd20000, 5'd5, mk(4000, 0, 0, 0, 22), 1'b1);
      wait_done();

      repeat (3) @(negedge ap_clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
